// File: rtl/ppm_channel_emu_if.sv
// Slot-in / observation-out handshake bundle for the PPM channel emulator.
// The master side feeds transmitted slots and consumes observations;
// the slave side is the emulator itself.
interface ppm_channel_emu_if #(
    parameter int LOG2L = 10
) ();
    logic [LOG2L-1:0] slot_in;
    logic             slot_valid;
    logic             slot_ready;
    logic [LOG2L:0]   obs_out;
    logic             obs_valid;
    logic             obs_ready;

    modport master (
        output slot_in, slot_valid, obs_ready,
        input  slot_ready, obs_out, obs_valid
    );

    modport slave (
        input  slot_in, slot_valid, obs_ready,
        output slot_ready, obs_out, obs_valid
    );
endinterface

// File: rtl/ppm_channel_emu.sv
// L-ary PPM erasure/error channel emulator.
// Each accepted slot is passed through unchanged (correct), replaced by the
// erasure code 2**LOG2L, or replaced by a uniformly drawn different slot.
// A 32-bit Galois LFSR supplies both the outcome draw and the wrong-slot
// candidate; it only advances while a draw is in progress so runs are
// reproducible from a seed regardless of handshake timing.
module ppm_channel_emu #(
    parameter int          LOG2L     = 10,
    parameter int          RND_W     = 16,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] SEED_DFLT = 32'hACE1_2468,
    parameter int          MAX_TRY   = 8
) (
    input  logic                 clk_12mhz,
    input  logic                 rst_n,
    input  logic                 cfg_bypass,
    input  logic [RND_W:0]       cfg_p_thr,
    input  logic [RND_W:0]       cfg_pq_thr,
    input  logic                 seed_load,
    input  logic [31:0]          cfg_seed,
    input  logic                 clr_cnt,
    ppm_channel_emu_if.slave     bus,
    output logic [CNT_W-1:0]     cnt_det,
    output logic [CNT_W-1:0]     cnt_era,
    output logic [CNT_W-1:0]     cnt_err
);

    localparam logic [31:0] TAPS  = 32'h8020_0003;
    localparam int          TRY_W = $clog2(MAX_TRY + 1);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        WRONG,
        OUT
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        lfsr_q;
    logic [31:0]        lfsr_step;
    logic [LOG2L-1:0]   slot_q;
    logic [LOG2L:0]     obs_q, obs_d;
    logic               obs_load;
    logic [TRY_W-1:0]   try_q, try_d;
    logic [RND_W:0]     rnd;
    logic [LOG2L-1:0]   cand;
    logic               cand_hit;
    logic               last_try;
    logic               wrong_pick;
    logic               inc_det, inc_era, inc_err;

    assign lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : '0);
    assign rnd       = {1'b0, lfsr_q[RND_W-1:0]};
    assign cand      = lfsr_q[31 -: LOG2L];
    assign cand_hit  = (cand == slot_q);
    // try_q counts equal draws already rejected; this draw would be the MAX_TRY-th
    assign last_try  = (try_q == TRY_W'(MAX_TRY - 1));

    assign bus.slot_ready = (state_q == IDLE);
    assign bus.obs_valid  = (state_q == OUT);
    assign bus.obs_out    = obs_q;

    // State register
    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, outcome selection and counter increment requests.
    // The first wrong-slot candidate is tried in DRAW itself, so a wrong
    // outcome with no rejected candidates has the same latency as a correct one.
    always_comb begin
        state_d    = state_q;
        try_d      = try_q;
        obs_load   = 1'b0;
        obs_d      = '0;
        inc_det    = 1'b0;
        inc_era    = 1'b0;
        inc_err    = 1'b0;
        wrong_pick = 1'b0;
        case (state_q)
            IDLE: begin
                try_d = '0;
                if (bus.slot_valid) begin
                    if (cfg_bypass) begin
                        state_d  = OUT;
                        obs_load = 1'b1;
                        obs_d    = {1'b0, bus.slot_in};
                    end else begin
                        state_d = DRAW;
                    end
                end
            end
            DRAW: begin
                if (rnd < cfg_p_thr) begin
                    state_d  = OUT;
                    obs_load = 1'b1;
                    obs_d    = {1'b0, slot_q};
                    inc_det  = 1'b1;
                end else if (rnd < cfg_pq_thr) begin
                    state_d  = OUT;
                    obs_load = 1'b1;
                    obs_d    = {1'b1, {LOG2L{1'b0}}};
                    inc_era  = 1'b1;
                end else begin
                    wrong_pick = 1'b1;
                end
            end
            WRONG: begin
                wrong_pick = 1'b1;
            end
            OUT: begin
                if (bus.obs_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (wrong_pick) begin
            if (!cand_hit) begin
                state_d  = OUT;
                obs_load = 1'b1;
                obs_d    = {1'b0, cand};
                inc_err  = 1'b1;
            end else if (last_try) begin
                state_d  = OUT;
                obs_load = 1'b1;
                obs_d    = {1'b0, slot_q ^ LOG2L'(1)};
                inc_err  = 1'b1;
            end else begin
                state_d = WRONG;
                try_d   = try_q + TRY_W'(1);
            end
        end
    end

    // Datapath registers: latched slot, observation, redraw count
    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
            obs_q  <= '0;
            try_q  <= '0;
        end else begin
            if (state_q == IDLE && bus.slot_valid) begin
                slot_q <= bus.slot_in;
            end
            if (obs_load) begin
                obs_q <= obs_d;
            end
            try_q <= try_d;
        end
    end

    // LFSR: seeded only while idle, advances only while drawing
    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED_DFLT;
        end else if (state_q == IDLE && seed_load) begin
            lfsr_q <= (cfg_seed == '0) ? SEED_DFLT : cfg_seed;
        end else if (state_q == DRAW || state_q == WRONG) begin
            lfsr_q <= lfsr_step;
        end
    end

    // Saturating outcome counters; a clear beats a same-cycle increment
    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_det <= '0;
            cnt_era <= '0;
            cnt_err <= '0;
        end else if (clr_cnt) begin
            cnt_det <= '0;
            cnt_era <= '0;
            cnt_err <= '0;
        end else begin
            if (inc_det && cnt_det != '1) cnt_det <= cnt_det + CNT_W'(1);
            if (inc_era && cnt_era != '1) cnt_era <= cnt_era + CNT_W'(1);
            if (inc_err && cnt_err != '1) cnt_err <= cnt_err + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ppm_channel_emu.sv
// Directed bench for ppm_channel_emu: each task drives one scenario and
// checks observations, latencies and counters against hand-derived values.
module tb_ppm_channel_emu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_bypass;
    logic [16:0] cfg_p_thr;
    logic [16:0] cfg_pq_thr;
    logic        seed_load;
    logic [31:0] cfg_seed;
    logic        clr_cnt;
    logic [15:0] cnt_det, cnt_era, cnt_err;

    int checks = 0;
    int passed = 0;

    ppm_channel_emu_if #(.LOG2L(10)) bus ();

    ppm_channel_emu #(
        .LOG2L    (10),
        .RND_W    (16),
        .CNT_W    (16),
        .SEED_DFLT(32'hACE1_2468),
        .MAX_TRY  (8)
    ) dut (
        .clk_12mhz (clk),
        .rst_n     (rst_n),
        .cfg_bypass(cfg_bypass),
        .cfg_p_thr (cfg_p_thr),
        .cfg_pq_thr(cfg_pq_thr),
        .seed_load (seed_load),
        .cfg_seed  (cfg_seed),
        .clr_cnt   (clr_cnt),
        .bus       (bus),
        .cnt_det   (cnt_det),
        .cnt_era   (cnt_era),
        .cnt_err   (cnt_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Send one slot; returns the observation and the number of clock edges
    // from the accept edge to the obs handshake edge (-1 on timeout).
    // With obs_ready low, returns as soon as obs_valid is seen.
    task automatic send_sym(input logic [9:0] s, output logic [10:0] o, output int lat);
        int w;
        o   = '0;
        lat = -1;
        @(negedge clk);
        bus.slot_in    = s;
        bus.slot_valid = 1'b1;
        w = 0;
        while (!bus.slot_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (bus.slot_ready) begin
            @(posedge clk);
            #1 bus.slot_valid = 1'b0;
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (bus.obs_valid) begin
                    o   = bus.obs_out;
                    lat = i;
                    break;
                end
            end
            if (lat > 0 && bus.obs_ready) @(posedge clk);
        end else begin
            bus.slot_valid = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
    endtask

    task automatic load_seed(input logic [31:0] s);
        @(negedge clk);
        cfg_seed  = s;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        cfg_bypass     = 1'b0;
        cfg_p_thr      = '0;
        cfg_pq_thr     = '0;
        seed_load      = 1'b0;
        cfg_seed       = '0;
        clr_cnt        = 1'b0;
        bus.slot_in    = '0;
        bus.slot_valid = 1'b0;
        bus.obs_ready  = 1'b1;
        #1;
        checks++; if (bus.slot_ready !== 1'b1) $display("FAIL reset_slot_ready got=%b exp=1", bus.slot_ready); else passed++;
        checks++; if (bus.obs_valid !== 1'b0) $display("FAIL reset_obs_valid got=%b exp=0", bus.obs_valid); else passed++;
        checks++; if (bus.obs_out !== 11'd0) $display("FAIL reset_obs_out got=%0d exp=0", bus.obs_out); else passed++;
        checks++; if ({cnt_det, cnt_era, cnt_err} !== 48'd0)
            $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", cnt_det, cnt_era, cnt_err); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_bypass();
        logic [10:0] o;
        int lat, bad_obs, bad_lat;
        bad_obs = 0; bad_lat = 0;
        pulse_clr();
        cfg_bypass = 1'b1;
        for (int s = 0; s < 1024; s++) begin
            send_sym(10'(s), o, lat);
            if (o !== 11'(s)) bad_obs++;
            if (lat != 1) bad_lat++;
        end
        checks++; if (bad_obs != 0) $display("FAIL bypass_obs bad=%0d exp=0", bad_obs); else passed++;
        checks++; if (bad_lat != 0) $display("FAIL bypass_latency bad=%0d exp=0 (last lat=%0d)", bad_lat, lat); else passed++;
        checks++; if ({cnt_det, cnt_era, cnt_err} !== 48'd0)
            $display("FAIL bypass_counters got=%0d/%0d/%0d exp=0/0/0", cnt_det, cnt_era, cnt_err); else passed++;
        cfg_bypass = 1'b0;
    endtask

    task automatic test_always_correct();
        logic [10:0] o;
        logic [9:0]  s;
        int lat, bad_obs, bad_lat;
        bad_obs = 0; bad_lat = 0;
        cfg_p_thr  = 17'd65536;
        cfg_pq_thr = 17'd0;   // below p_thr: must not create erasures
        pulse_clr();
        for (int i = 0; i < 200; i++) begin
            s = 10'($urandom_range(1023));
            send_sym(s, o, lat);
            if (o !== {1'b0, s}) bad_obs++;
            if (lat != 2) bad_lat++;
        end
        checks++; if (bad_obs != 0) $display("FAIL correct_obs bad=%0d exp=0", bad_obs); else passed++;
        checks++; if (bad_lat != 0) $display("FAIL correct_latency bad=%0d exp=0", bad_lat); else passed++;
        checks++; if (cnt_det !== 16'd200) $display("FAIL correct_cnt_det got=%0d exp=200", cnt_det); else passed++;
        checks++; if ({cnt_era, cnt_err} !== 32'd0) $display("FAIL correct_other_cnts got=%0d/%0d exp=0/0", cnt_era, cnt_err); else passed++;
    endtask

    task automatic test_always_erasure();
        logic [10:0] o;
        int lat, bad;
        bad = 0;
        cfg_p_thr  = 17'd0;
        cfg_pq_thr = 17'd65536;
        pulse_clr();
        for (int i = 0; i < 100; i++) begin
            send_sym(10'($urandom_range(1023)), o, lat);
            if (o !== 11'd1024 || lat != 2) bad++;
        end
        checks++; if (bad != 0) $display("FAIL erasure_obs bad=%0d exp=0 (last obs=%0d lat=%0d)", bad, o, lat); else passed++;
        checks++; if (cnt_era !== 16'd100) $display("FAIL erasure_cnt_era got=%0d exp=100", cnt_era); else passed++;
        checks++; if ({cnt_det, cnt_err} !== 32'd0) $display("FAIL erasure_other_cnts got=%0d/%0d exp=0/0", cnt_det, cnt_err); else passed++;
    endtask

    task automatic test_always_wrong();
        logic [10:0] o;
        logic [9:0]  s;
        int lat, bad;
        bad = 0;
        cfg_p_thr  = 17'd0;
        cfg_pq_thr = 17'd0;
        pulse_clr();
        for (int i = 0; i < 2000; i++) begin
            s = (i == 0) ? 10'd0 : (i == 1) ? 10'd1023 : 10'($urandom_range(1023));
            send_sym(s, o, lat);
            if (o >= 11'd1024 || o[9:0] == s || lat < 2 || lat > 9) bad++;
        end
        checks++; if (bad != 0) $display("FAIL wrong_obs bad=%0d exp=0", bad); else passed++;
        checks++; if (cnt_err !== 16'd2000) $display("FAIL wrong_cnt_err got=%0d exp=2000", cnt_err); else passed++;
    endtask

    task automatic test_backpressure();
        logic [10:0] o;
        int lat, bad;
        bad = 0;
        cfg_p_thr  = 17'd65536;
        cfg_pq_thr = 17'd65536;
        pulse_clr();
        bus.obs_ready = 1'b0;
        send_sym(10'd100, o, lat);
        checks++; if (o !== 11'd100 || lat != 2) $display("FAIL stall_first_obs got=%0d lat=%0d exp=100 lat=2", o, lat); else passed++;
        bus.slot_in    = 10'd200;
        bus.slot_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.obs_valid !== 1'b1 || bus.obs_out !== 11'd100 || bus.slot_ready !== 1'b0) bad++;
        end
        checks++; if (bad != 0) $display("FAIL stall_hold bad=%0d exp=0", bad); else passed++;
        bus.slot_valid = 1'b0;
        bus.obs_ready  = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.obs_valid !== 1'b0) $display("FAIL stall_release obs_valid=%b exp=0", bus.obs_valid); else passed++;
        send_sym(10'd200, o, lat);
        checks++; if (o !== 11'd200 || lat != 2) $display("FAIL stall_second_obs got=%0d lat=%0d exp=200 lat=2", o, lat); else passed++;
        checks++; if (cnt_det !== 16'd2) $display("FAIL stall_cnt_det got=%0d exp=2", cnt_det); else passed++;
    endtask

    task automatic test_seed_repeat();
        logic [9:0]  slots [1000];
        logic [10:0] obs_a [1000];
        logic [10:0] o;
        int lat, diff, n_det;
        diff = 0; n_det = 0;
        cfg_p_thr  = 17'd45875;
        cfg_pq_thr = 17'd49152;
        for (int i = 0; i < 1000; i++) slots[i] = 10'($urandom_range(1023));
        load_seed(32'h1);
        for (int i = 0; i < 1000; i++) begin
            send_sym(slots[i], o, lat);
            obs_a[i] = o;
            if (o == {1'b0, slots[i]}) n_det++;
        end
        load_seed(32'h1);
        for (int i = 0; i < 1000; i++) begin
            send_sym(slots[i], o, lat);
            if (o !== obs_a[i]) diff++;
        end
        checks++; if (diff != 0) $display("FAIL seed_repeat differing=%0d exp=0", diff); else passed++;
        checks++; if (n_det < 500 || n_det > 900) $display("FAIL seed_repeat_mix correct=%0d exp 500..900", n_det); else passed++;
    endtask

    // Seed 1: first draw has candidate 0 (rejected for slot 0), next state
    // 0x80200003 gives candidate 512. Zero seed uses 0xACE12468: candidate
    // 691 rejected for slot 691, next state 0x56709234 gives candidate 345.
    task automatic test_seed_values();
        logic [10:0] o;
        int lat;
        cfg_p_thr  = 17'd0;
        cfg_pq_thr = 17'd0;
        load_seed(32'h1);
        send_sym(10'd0, o, lat);
        checks++; if (o !== 11'd512 || lat != 3) $display("FAIL seed1_wrong got=%0d lat=%0d exp=512 lat=3", o, lat); else passed++;
        load_seed(32'h0);
        send_sym(10'd691, o, lat);
        checks++; if (o !== 11'd345 || lat != 3) $display("FAIL seed0_default got=%0d lat=%0d exp=345 lat=3", o, lat); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [10:0] o;
        int lat;
        cfg_p_thr  = 17'd0;
        cfg_pq_thr = 17'd0;
        load_seed(32'h1);
        @(negedge clk);
        bus.slot_in    = 10'd0;
        bus.slot_valid = 1'b1;
        @(posedge clk);
        #1 bus.slot_valid = 1'b0;
        @(posedge clk);   // DRAW rejects candidate 0 -> WRONG
        @(negedge clk);
        checks++; if (bus.slot_ready !== 1'b0 || cnt_err === 16'd0)
            $display("FAIL midwrong_pre slot_ready=%b cnt_err=%0d exp=0,nonzero", bus.slot_ready, cnt_err); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.slot_ready !== 1'b1 || bus.obs_valid !== 1'b0)
            $display("FAIL midwrong_reset slot_ready=%b obs_valid=%b exp=1,0", bus.slot_ready, bus.obs_valid); else passed++;
        checks++; if ({cnt_det, cnt_era, cnt_err} !== 48'd0)
            $display("FAIL midwrong_counters got=%0d/%0d/%0d exp=0/0/0", cnt_det, cnt_era, cnt_err); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        cfg_bypass    = 1'b1;
        bus.obs_ready = 1'b0;
        send_sym(10'd5, o, lat);
        checks++; if (bus.obs_valid !== 1'b1 || o !== 11'd5) $display("FAIL pending_obs valid=%b obs=%0d exp=1,5", bus.obs_valid, o); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.obs_valid !== 1'b0 || bus.obs_out !== 11'd0)
            $display("FAIL pending_reset obs_valid=%b obs_out=%0d exp=0,0", bus.obs_valid, bus.obs_out); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        cfg_bypass    = 1'b0;
        bus.obs_ready = 1'b1;
    endtask

    task automatic test_statistics();
        logic [10:0] o;
        int lat;
        cfg_p_thr  = 17'd45875;
        cfg_pq_thr = 17'd49152;
        load_seed(32'h1);
        pulse_clr();
        for (int i = 0; i < 10000; i++) send_sym(10'($urandom_range(1023)), o, lat);
        checks++; if (cnt_det < 16'd6700 || cnt_det > 16'd7300) $display("FAIL stat_det got=%0d exp 6700..7300", cnt_det); else passed++;
        checks++; if (cnt_era < 16'd350 || cnt_era > 16'd650) $display("FAIL stat_era got=%0d exp 350..650", cnt_era); else passed++;
        checks++; if (cnt_err < 16'd2200 || cnt_err > 16'd2800) $display("FAIL stat_err got=%0d exp 2200..2800", cnt_err); else passed++;
        checks++; if (32'(cnt_det) + 32'(cnt_era) + 32'(cnt_err) != 32'd10000)
            $display("FAIL stat_total got=%0d exp=10000", 32'(cnt_det) + 32'(cnt_era) + 32'(cnt_err)); else passed++;
    endtask

    task automatic test_clr_priority();
        logic [10:0] o;
        int lat;
        cfg_p_thr  = 17'd65536;
        pulse_clr();
        checks++; if ({cnt_det, cnt_era, cnt_err} !== 48'd0)
            $display("FAIL clr_counters got=%0d/%0d/%0d exp=0/0/0", cnt_det, cnt_era, cnt_err); else passed++;
        @(negedge clk);
        bus.slot_in    = 10'd7;
        bus.slot_valid = 1'b1;
        @(posedge clk);   // accept
        #1 bus.slot_valid = 1'b0;
        @(negedge clk);
        clr_cnt = 1'b1;   // coincides with the DRAW->OUT increment edge
        @(negedge clk);
        clr_cnt = 1'b0;
        checks++; if (cnt_det !== 16'd0) $display("FAIL clr_beats_inc cnt_det=%0d exp=0", cnt_det); else passed++;
        @(posedge clk);   // OUT handshake
        send_sym(10'd8, o, lat);
        checks++; if (cnt_det !== 16'd1 || o !== 11'd8) $display("FAIL clr_after cnt_det=%0d obs=%0d exp=1,8", cnt_det, o); else passed++;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_always_correct();
        test_always_erasure();
        test_always_wrong();
        test_backpressure();
        test_seed_repeat();
        test_seed_values();
        test_reset_mid();
        test_statistics();
        test_clr_priority();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
